// File: rtl/beam_scanner.sv
// beam_scanner: raster timing generator producing beam coordinates, syncs, line/frame strobes and a frame count.
module beam_scanner #(
    parameter int H_VISIBLE    = 800,
    parameter int H_FRONT      = 56,
    parameter int H_SYNC       = 120,
    parameter int H_BACK       = 64,
    parameter int V_VISIBLE    = 600,
    parameter int V_FRONT      = 37,
    parameter int V_SYNC       = 6,
    parameter int V_BACK       = 23,
    parameter bit HSYNC_ACTIVE = 1'b1,
    parameter bit VSYNC_ACTIVE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [10:0] beam_x,
    output logic [9:0]  beam_y,
    output logic        visible,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_timing
        $error("beam_scanner: H_TOTAL/V_TOTAL exceed counter widths");
    end
    logic        x_wrap, y_wrap;
    logic [10:0] nx;
    logic [9:0]  ny;
    always_comb begin
        x_wrap = beam_x == 11'(H_TOTAL - 1);
        y_wrap = beam_y == 10'(V_TOTAL - 1);
        nx = x_wrap ? 11'd0 : beam_x + 11'd1;
        ny = !x_wrap ? beam_y : y_wrap ? 10'd0 : beam_y + 10'd1;
    end
    // Flags are derived from the next position so they stay aligned with beam_x/beam_y.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            beam_x      <= 11'(H_TOTAL - 1);
            beam_y      <= 10'(V_TOTAL - 1);
            visible     <= 1'b0;
            hsync       <= !HSYNC_ACTIVE;
            vsync       <= !VSYNC_ACTIVE;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 16'd0;
        end else if (pix_en) begin
            beam_x      <= nx;
            beam_y      <= ny;
            visible     <= int'(nx) < H_VISIBLE && int'(ny) < V_VISIBLE;
            hsync       <= (int'(nx) >= H_VISIBLE + H_FRONT && int'(nx) < H_VISIBLE + H_FRONT + H_SYNC) ? HSYNC_ACTIVE : !HSYNC_ACTIVE;
            vsync       <= (int'(ny) >= V_VISIBLE + V_FRONT && int'(ny) < V_VISIBLE + V_FRONT + V_SYNC) ? VSYNC_ACTIVE : !VSYNC_ACTIVE;
            line_start  <= x_wrap;
            frame_start <= x_wrap && y_wrap;
            frame_count <= frame_count + 16'(x_wrap && y_wrap);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
endmodule

// File: tb/tb_beam_scanner.sv
// tb_beam_scanner: checks beam_scanner against a step-count model of the raster plus directed literal checks.
module tb_beam_scanner;
    localparam int HT = 1040;
    localparam int VT = 666;
    localparam longint FR = longint'(HT) * VT;
    logic        clk, rst, pix_en;
    logic [10:0] beam_x;
    logic [9:0]  beam_y;
    logic        visible, hsync, vsync, line_start, frame_start;
    logic [15:0] frame_count;
    beam_scanner dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .beam_x(beam_x), .beam_y(beam_y),
        .visible(visible), .hsync(hsync), .vsync(vsync), .line_start(line_start),
        .frame_start(frame_start), .frame_count(frame_count)
    );
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    int     total = 0, bad = 0;
    longint n, jump_n, fc_off;
    bit     stepped, jump_req, chk_on, tog;
    logic [10:0] fx;
    logic [9:0]  fy;
    task automatic check(string nm, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    // Model: the whole raster is a function of how many pix_en steps happened since reset.
    always @(posedge clk or posedge rst)
        if (rst) begin
            n <= 0;
            stepped <= 0;
        end else begin
            stepped <= pix_en;
            if (jump_req) n <= jump_n + 1;
            else if (pix_en) n <= n + 1;
        end
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            longint p;
            int ex, ey;
            p  = (n == 0) ? FR - 1 : (n - 1) % FR;
            ex = int'(p % HT);
            ey = int'(p / HT);
            check("cmp_x", beam_x, ex);
            check("cmp_y", beam_y, ey);
            check("cmp_visible", visible, (ex < 800 && ey < 600) ? 1 : 0);
            check("cmp_hsync", hsync, (ex >= 856 && ex < 976) ? 1 : 0);
            check("cmp_vsync", vsync, (ey >= 637 && ey < 643) ? 1 : 0);
            check("cmp_line_start", line_start, (stepped && ex == 0) ? 1 : 0);
            check("cmp_frame_start", frame_start, (stepped && ex == 0 && ey == 0) ? 1 : 0);
            check("cmp_frame_count", frame_count, (n == 0) ? 0 : (((n - 1) / FR + 1 + fc_off) & 64'hffff));
        end
    end
    // Teleport the counters to (x,y) in the current frame; the following step lands on (x+1,y).
    task automatic jump(int x, int y);
        @(posedge clk);
        #2;
        chk_on = 0;
        pix_en = 1;
        fx = 11'(x);
        fy = 10'(y);
        force dut.beam_x = fx;
        force dut.beam_y = fy;
        #1;
        release dut.beam_x;
        release dut.beam_y;
        jump_n = ((n - 1) / FR) * FR + longint'(y) * HT + x + 1;
        jump_req = 1;
        @(posedge clk);
        #1;
        jump_req = 0;
        chk_on = 1;
    endtask
    initial begin
        int cnt, first, last, py, c;
        bit found;
        rst = 0; pix_en = 0; chk_on = 0; jump_req = 0; fc_off = 0; tog = 1;
        #2 rst = 1;
        #1;
        check("rst_x", beam_x, 1039);
        check("rst_y", beam_y, 665);
        check("rst_visible", visible, 0);
        check("rst_hsync", hsync, 0);
        check("rst_vsync", vsync, 0);
        check("rst_fc", frame_count, 0);
        check("rst_ls", line_start, 0);
        chk_on = 1;
        @(posedge clk);
        #2 rst = 0; pix_en = 1;
        @(posedge clk);
        #1;
        check("first_x", beam_x, 0);
        check("first_y", beam_y, 0);
        check("first_visible", visible, 1);
        check("first_fs", frame_start, 1);
        check("first_ls", line_start, 1);
        check("first_fc", frame_count, 1);
        @(posedge clk);
        #1;
        check("second_x", beam_x, 1);
        check("second_fs", frame_start, 0);
        check("second_ls", line_start, 0);
        // one full line of horizontal timing
        cnt = 0; first = -1; last = -1; py = -1;
        repeat (HT) begin
            @(negedge clk);
            if (hsync) begin
                cnt++;
                if (first < 0) first = int'(beam_x);
                last = int'(beam_x);
            end
            if (!visible && beam_y == 0 && py < 0) py = int'(beam_x);
        end
        check("hsync_len", cnt, 120);
        check("hsync_first", first, 856);
        check("hsync_last", last, 975);
        check("visible_fall_x", py, 800);
        found = 0;
        for (int i = 0; i < 2 * HT && !found; i++) begin
            @(posedge clk);
            #1;
            found = beam_x == 11'd1039;
        end
        check("reach_1039", found, 1);
        py = int'(beam_y);
        @(posedge clk);
        #1;
        check("wrap_x", beam_x, 0);
        check("wrap_ls", line_start, 1);
        check("wrap_y", beam_y, py + 1);
        // vertical sync window
        jump(1030, 636);
        cnt = 0; first = -1; last = -1;
        repeat (8 * HT) begin
            @(negedge clk);
            if (vsync) begin
                cnt++;
                if (first < 0) first = int'(beam_y);
                last = int'(beam_y);
            end
        end
        check("vsync_len", cnt, 6 * HT);
        check("vsync_first_y", first, 637);
        check("vsync_last_y", last, 642);
        // frame_count wrap across the end of frame
        @(posedge clk);
        #2 chk_on = 0;
        force dut.frame_count = 16'hffff;
        #1 release dut.frame_count;
        fc_off = 65535 - ((n - 1) / FR + 1);
        jump(1035, 665);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            found = frame_start;
        end
        check("fs_seen", found, 1);
        check("fc_wrap", frame_count, 0);
        check("fs_x", beam_x, 0);
        check("fs_y", beam_y, 0);
        // enable gating at (0,0)
        pix_en = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("hold_x", beam_x, 0);
            check("hold_y", beam_y, 0);
            check("hold_fs", frame_start, 0);
            check("hold_fc", frame_count, 0);
        end
        // 1-of-2 enable doubles the line period
        jump(1030, 5);
        fork
            while (tog) begin
                @(posedge clk);
                #2 pix_en = ~pix_en;
            end
            begin
                found = 0;
                for (int i = 0; i < 100 && !found; i++) begin
                    @(posedge clk);
                    #1;
                    found = line_start;
                end
                check("toggle_ls_seen", found, 1);
                c = 0;
                do begin
                    @(posedge clk);
                    #1;
                    c++;
                end while (!line_start && c < 5000);
                check("toggle_period", c, 2080);
                tog = 0;
            end
        join
        // asynchronous reset mid-frame
        jump(399, 300);
        pix_en = 0;
        check("pre_rst_x", beam_x, 400);
        @(negedge clk);
        #1 rst = 1; fc_off = 0;
        #1;
        check("mid_rst_x", beam_x, 1039);
        check("mid_rst_y", beam_y, 665);
        check("mid_rst_visible", visible, 0);
        check("mid_rst_fc", frame_count, 0);
        #2 rst = 0;
        @(posedge clk);
        #2 pix_en = 1;
        @(posedge clk);
        #1;
        check("post_rst_x", beam_x, 0);
        check("post_rst_y", beam_y, 0);
        check("post_rst_fs", frame_start, 1);
        check("post_rst_fc", frame_count, 1);
        repeat (20) @(posedge clk);
        #1;
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
